vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart to the vga display block. Samples an incoming hsync/vsync/RGB pixel stream clocked by dclk and thresholds each active pixel to 1 bit.
- Rebuilds a flattened WIDTH x HEIGHT bitmap in the same format mySobel consumes.
- Lets the display output loop back into the edge-detector path, and gives benches a frame checker.

Parameters:
- WIDTH, 9, active pixels per line
- HEIGHT, 9, active lines per frame
- H_BP, 48, dclk cycles from hsync deassertion to first active pixel
- V_BP, 33, hsync pulses after vsync deassertion before first active line
- THRESH, 11, pixel = 1 when red+green+blue >= THRESH

Ports:
- dclk  in  1  pixel clock, all logic on rising edge
- clr  in  1  synchronous active-low reset
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- red  in  3  pixel red
- green  in  3  pixel green
- blue  in  3  pixel blue
- bmpOutput  out  [0:WIDTH*HEIGHT-1]  last complete frame; bit 0 = top-left, index = row*WIDTH+col
- frame_done  out  1  one-cycle pulse when bmpOutput updates
- frame_err  out  1  one-cycle pulse on malformed frame
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset: clr low at a dclk edge sets the FSM to IDLE. It also sets bmpOutput, frame_done, frame_err, frame_count and all counters to 0, and clears the working buffer. Reset has priority over every other event.
- Input stage: hsync, vsync, red, green and blue are registered once. Edges are detected from the registered value versus its previous copy.
- Pixel value: 5-bit unsigned sum red+green+blue (range 0..21), compared with THRESH.
- Frame FSM:
  - IDLE: wait for vsync assertion (high->low).
  - VSYNC: wait for vsync deassertion. Clear the line counter and working buffer.
  - VBP: count hsync deassertion edges. The (V_BP+1)-th edge enters ACTIVE with row=0.
  - ACTIVE: run the line sub-FSM. At each later hsync deassertion, row increments. When row HEIGHT-1 completes, go to COMMIT.
  - COMMIT: copy the working buffer to bmpOutput, pulse frame_done, increment frame_count, then return to IDLE.
- Line sub-FSM (in ACTIVE):
  - Let T0 be the dclk edge at which raw hsync is first sampled high after being low.
  - Pixel col c (0..WIDTH-1) is the raw RGB sampled at edge T0+H_BP+c.
  - After col WIDTH-1, ignore samples (front porch) until the next hsync assertion.
- Latency: if Tlast is the edge sampling the last pixel of row HEIGHT-1, then bmpOutput changes and frame_done is high in the cycle starting at edge Tlast+2. bmpOutput is otherwise stable and never shows a partial frame.
- Errors (frame_err pulses one cycle, working buffer discarded, bmpOutput and frame_count unchanged):
  - vsync asserts during VBP or ACTIVE: go directly to VSYNC, so the new frame is captured.
  - hsync asserts in ACTIVE before col WIDTH-1 is sampled: go to IDLE.
- Extra lines after row HEIGHT-1 before vsync are ignored. This is not an error.
- Reset released mid-frame: IDLE ignores everything until a fresh vsync assertion, so no partial frame commits.
- vsync and hsync edges in the same cycle: vsync handling wins.
- H_BP=0 is legal: col 0 is sampled at T0.

Test Plan:
- Nominal frame, WIDTH=HEIGHT=9, H_BP=4, V_BP=2, row-major checkerboard (RGB 7,7,7 vs 0,0,0) -> bmpOutput alternating 1/0 starting with bit 0=1; frame_done one pulse at Tlast+2; frame_count=1.
- Threshold boundary: all pixels RGB sum 11, then a second frame with sum 10 -> first bmpOutput all ones, second all zeros; frame_count=2.
- vsync asserted during row 4 -> frame_err pulse; bmpOutput keeps the previous frame; the next full frame commits normally.
- Short line (hsync asserted after col 5 of row 3) -> frame_err; bmpOutput unchanged; FSM waits for the next vsync.
- clr low for one cycle mid-ACTIVE, stream continues -> all outputs 0, no frame_done for the interrupted frame, the following full frame commits with frame_count=1.
- 256 consecutive good frames -> frame_count wraps to 0; frame_done pulses 256 times.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: receives an hsync/vsync/RGB pixel stream on dclk and thresholds
// each active pixel to one bit. It rebuilds a flattened WIDTH x HEIGHT bitmap
// (bit 0 = top-left, index = row*WIDTH+col) and publishes it only once the
// whole frame is complete.
module vga_capture #(
    parameter int WIDTH  = 9,
    parameter int HEIGHT = 9,
    parameter int H_BP   = 48,
    parameter int V_BP   = 33,
    parameter int THRESH = 11
) (
    input  logic                      dclk,
    input  logic                      clr,
    input  logic                      hsync,
    input  logic                      vsync,
    input  logic [2:0]                red,
    input  logic [2:0]                green,
    input  logic [2:0]                blue,
    output logic [0:WIDTH*HEIGHT-1]   bmpOutput,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic [7:0]                frame_count
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int POSW = $clog2(H_BP + WIDTH + 1);
    localparam int ROWW = $clog2(HEIGHT + 1);
    localparam int VW   = $clog2(V_BP + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic              hsync_q, hsync_d, hsync_prev_q, hsync_prev_d;
    logic              vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
    logic [2:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [ROWW-1:0]   row_q, row_d;
    logic [POSW-1:0]   pos_q, pos_d;
    logic              line_act_q, line_act_d;
    logic [0:NPIX-1]   work_q, work_d;
    logic [0:NPIX-1]   bmp_q, bmp_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        count_q, count_d;

    logic              vs_fall, vs_rise, hs_fall, hs_rise;
    logic [4:0]        pix_sum;
    logic              pix_on;
    logic              line_start, capturing;
    logic [ROWW-1:0]   row_cur;
    logic [POSW-1:0]   pos_cur;
    logic [IDXW-1:0]   idx;

    // Input stage: one register layer plus a delayed copy of the syncs for edge detection.
    always_comb begin
        hsync_d      = hsync;
        vsync_d      = vsync;
        red_d        = red;
        green_d      = green;
        blue_d       = blue;
        hsync_prev_d = hsync_q;
        vsync_prev_d = vsync_q;
    end

    // Sync edges (assertion = falling, both syncs active-low) and the thresholded pixel.
    always_comb begin
        vs_fall = vsync_prev_q & ~vsync_q;
        vs_rise = ~vsync_prev_q & vsync_q;
        hs_fall = hsync_prev_q & ~hsync_q;
        hs_rise = ~hsync_prev_q & hsync_q;
        pix_sum = {2'b00, red_q} + {2'b00, green_q} + {2'b00, blue_q};
        pix_on  = (int'(pix_sum) >= THRESH);
    end

    // Frame FSM with the embedded line sub-FSM; a new line starts on the hsync deassertion edge.
    always_comb begin
        state_d    = state_q;
        vcnt_d     = vcnt_q;
        row_d      = row_q;
        pos_d      = pos_q;
        line_act_d = line_act_q;
        work_d     = work_q;
        bmp_d      = bmp_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        count_d    = count_q;
        line_start = 1'b0;
        capturing  = 1'b0;
        row_cur    = row_q;
        pos_cur    = pos_q;
        idx        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (vs_fall) state_d = S_VSYNC;
            end
            S_VSYNC: begin
                vcnt_d     = '0;
                row_d      = '0;
                line_act_d = 1'b0;
                work_d     = '0;
                if (vs_rise) state_d = S_VBP;
            end
            S_VBP: begin
                if (vs_fall) begin
                    err_d   = 1'b1;
                    state_d = S_VSYNC;
                end else if (hs_rise) begin
                    if (int'(vcnt_q) == V_BP) begin
                        state_d    = S_ACTIVE;
                        line_start = 1'b1;
                        row_cur    = '0;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (vs_fall) begin
                    err_d      = 1'b1;
                    line_act_d = 1'b0;
                    state_d    = S_VSYNC;
                end else if (hs_fall && line_act_q) begin
                    err_d      = 1'b1;
                    line_act_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (hs_rise) begin
                    line_start = 1'b1;
                    row_cur    = row_q + 1'b1;
                end else begin
                    capturing = line_act_q;
                end
            end
            S_COMMIT: begin
                bmp_d   = work_q;
                done_d  = 1'b1;
                count_d = count_q + 8'd1;
                state_d = vs_fall ? S_VSYNC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (line_start || capturing) begin
            pos_cur    = line_start ? '0 : pos_q;
            row_d      = row_cur;
            line_act_d = 1'b1;
            pos_d      = pos_cur + 1'b1;
            if (int'(pos_cur) >= H_BP) begin
                idx         = IDXW'(int'(row_cur) * WIDTH + int'(pos_cur) - H_BP);
                work_d[idx] = pix_on;
                if (int'(pos_cur) - H_BP == WIDTH - 1) begin
                    line_act_d = 1'b0;
                    if (int'(row_cur) == HEIGHT - 1) state_d = S_COMMIT;
                end
            end
        end
    end

    // State register; reset clears everything including the working buffer.
    always_ff @(posedge dclk) begin
        if (!clr) begin
            state_q      <= S_IDLE;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            hsync_prev_q <= 1'b0;
            vsync_prev_q <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            vcnt_q       <= '0;
            row_q        <= '0;
            pos_q        <= '0;
            line_act_q   <= 1'b0;
            work_q       <= '0;
            bmp_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            hsync_prev_q <= hsync_prev_d;
            vsync_prev_q <= vsync_prev_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            vcnt_q       <= vcnt_d;
            row_q        <= row_d;
            pos_q        <= pos_d;
            line_act_q   <= line_act_d;
            work_q       <= work_d;
            bmp_q        <= bmp_d;
            done_q       <= done_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    assign bmpOutput   = bmp_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture: drives synthetic VGA frames with random pixel
// data and compares the captured bitmap, pulses and frame counter against a
// reference computed directly from the pixel arrays.
module tb_vga_capture;

    localparam int W    = 9;
    localparam int H    = 9;
    localparam int HBP  = 4;
    localparam int VBP  = 2;
    localparam int TH   = 11;
    localparam int NPIX = W * H;

    logic            dclk  = 1'b0;
    logic            clr   = 1'b0;
    logic            hsync = 1'b1;
    logic            vsync = 1'b1;
    logic [2:0]      red   = '0;
    logic [2:0]      green = '0;
    logic [2:0]      blue  = '0;
    logic [0:NPIX-1] bmpOutput;
    logic            frame_done;
    logic            frame_err;
    logic [7:0]      frame_count;

    vga_capture #(
        .WIDTH (W),
        .HEIGHT(H),
        .H_BP  (HBP),
        .V_BP  (VBP),
        .THRESH(TH)
    ) dut (
        .dclk       (dclk),
        .clr        (clr),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .bmpOutput  (bmpOutput),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_count(frame_count)
    );

    always #5 dclk = ~dclk;

    // Edge counter and the clr level seen at each edge.
    int   cyc = 0;
    logic clrAtEdge = 1'b0;
    always @(posedge dclk) begin
        cyc       <= cyc + 1;
        clrAtEdge <= clr;
    end

    // Output monitor: counts pulse cycles and flags bitmap changes without frame_done.
    int              doneCount   = 0;
    int              errCount    = 0;
    int              glitchCount = 0;
    int              lastDoneCyc = -1;
    logic [0:NPIX-1] prevBmp     = '0;
    always @(negedge dclk) begin
        if (frame_done === 1'b1) begin
            doneCount   = doneCount + 1;
            lastDoneCyc = cyc;
        end
        if (frame_err === 1'b1) errCount = errCount + 1;
        if (clrAtEdge && frame_done !== 1'b1 && bmpOutput !== prevBmp) glitchCount = glitchCount + 1;
        prevBmp = bmpOutput;
    end

    int              errors = 0;
    int              checks = 0;
    int              pixR[NPIX];
    int              pixG[NPIX];
    int              pixB[NPIX];
    logic [0:NPIX-1] expBmp;
    logic [0:NPIX-1] keepBmp;
    logic [7:0]      expCount;
    int              tLast = 0;
    logic            clrNext = 1'b0;
    int              d0;
    int              e0;

    task automatic applyStimulus(input logic hs, input logic vs, input int r, input int g, input int b);
        @(posedge dclk);
        #2;
        hsync = hs;
        vsync = vs;
        red   = 3'(r);
        green = 3'(g);
        blue  = 3'(b);
        clr   = clrNext;
    endtask

    task automatic junk(input logic hs, input logic vs);
        applyStimulus(hs, vs, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a pixel is 1 when its channel sum reaches the threshold.
    function automatic logic [0:NPIX-1] modelBitmap();
        logic [0:NPIX-1] b;
        for (int i = 0; i < NPIX; i++) b[i] = (pixR[i] + pixG[i] + pixB[i]) >= TH;
        return b;
    endfunction

    task automatic fillRandom();
        for (int i = 0; i < NPIX; i++) begin
            pixR[i] = int'($urandom_range(0, 7));
            pixG[i] = int'($urandom_range(0, 7));
            pixB[i] = int'($urandom_range(0, 7));
        end
    endtask

    task automatic fillChecker();
        for (int i = 0; i < NPIX; i++) begin
            pixR[i] = (i % 2 == 0) ? 7 : 0;
            pixG[i] = pixR[i];
            pixB[i] = pixR[i];
        end
    endtask

    task automatic fillSum(input int s);
        int rem;
        for (int i = 0; i < NPIX; i++) begin
            pixR[i] = int'($urandom_range((s > 14) ? s - 14 : 0, (s < 7) ? s : 7));
            rem     = s - pixR[i];
            pixG[i] = int'($urandom_range((rem > 7) ? rem - 7 : 0, (rem < 7) ? rem : 7));
            pixB[i] = rem - pixG[i];
        end
    endtask

    // One line: hsync low for 2 cycles, then back porch, pixels and front porch.
    // row < 0 sends a porch/extra line of random data. Returns 1 if the line was cut short.
    task automatic sendLine(input int row, input int abortCol, input int shortCol, input int rstCol, output bit cut);
        int c;
        int p;
        cut = 1'b0;
        repeat (2) junk(1'b0, 1'b1);
        for (int k = 0; k < HBP + W + 2; k++) begin
            c = k - HBP;
            if (row >= 0 && c >= 0 && c < W) begin
                p = row * W + c;
                if (c == rstCol) clrNext = 1'b0;
                applyStimulus(1'b1, 1'b1, pixR[p], pixG[p], pixB[p]);
                clrNext = 1'b1;
                if (row == H - 1 && c == W - 1) tLast = cyc + 1;
                if (c == abortCol) begin
                    junk(1'b1, 1'b0);
                    cut = 1'b1;
                    return;
                end
                if (c == shortCol) begin
                    junk(1'b0, 1'b1);
                    junk(1'b0, 1'b1);
                    junk(1'b1, 1'b1);
                    cut = 1'b1;
                    return;
                end
            end else begin
                junk(1'b1, 1'b1);
            end
        end
    endtask

    task automatic sendFrame(input int abortRow, input int shortRow, input int rstRow);
        bit cut;
        repeat (3) junk(1'b1, 1'b0);
        repeat (2) junk(1'b1, 1'b1);
        repeat (VBP) sendLine(-1, -1, -1, -1, cut);
        for (int r = 0; r < H; r++) begin
            sendLine(r, (r == abortRow) ? 3 : -1, (r == shortRow) ? 5 : -1, (r == rstRow) ? 2 : -1, cut);
            if (cut) return;
        end
        sendLine(-1, -1, -1, -1, cut);
        repeat (3) junk(1'b1, 1'b1);
    endtask

    initial begin
        // Reset state
        clrNext = 1'b0;
        repeat (4) junk(1'b1, 1'b1);
        clrNext = 1'b1;
        junk(1'b1, 1'b1);
        checkOutput("reset_bmp", bmpOutput, '0);
        checkOutput("reset_done", frame_done, 1'b0);
        checkOutput("reset_err", frame_err, 1'b0);
        checkOutput("reset_count", frame_count, 8'd0);
        expCount = 8'd0;

        // Nominal checkerboard frame with commit latency
        fillChecker();
        expBmp = modelBitmap();
        d0 = doneCount;
        sendFrame(-1, -1, -1);
        expCount = expCount + 8'd1;
        checkOutput("checker_bmp", bmpOutput, expBmp);
        checkOutput("checker_bit0", bmpOutput[0], 1'b1);
        checkOutput("checker_done_pulses", doneCount - d0, 1);
        checkOutput("checker_done_latency", lastDoneCyc, tLast + 2);
        checkOutput("checker_count", frame_count, expCount);
        checkOutput("checker_no_err", errCount, 0);

        // Threshold boundary: sum 11 -> ones, sum 10 -> zeros
        fillSum(TH);
        sendFrame(-1, -1, -1);
        expCount = expCount + 8'd1;
        checkOutput("thresh_eq_bmp", bmpOutput, {NPIX{1'b1}});
        checkOutput("thresh_eq_count", frame_count, expCount);
        fillSum(TH - 1);
        d0 = doneCount;
        sendFrame(-1, -1, -1);
        expCount = expCount + 8'd1;
        checkOutput("thresh_lt_bmp", bmpOutput, {NPIX{1'b0}});
        checkOutput("thresh_lt_latency", lastDoneCyc, tLast + 2);
        checkOutput("thresh_lt_pulses", doneCount - d0, 1);

        // vsync asserted during row 4, then a good frame
        keepBmp = bmpOutput;
        e0 = errCount;
        d0 = doneCount;
        fillRandom();
        sendFrame(4, -1, -1);
        repeat (3) @(posedge dclk);
        checkOutput("vabort_err", errCount - e0, 1);
        checkOutput("vabort_bmp_kept", bmpOutput, keepBmp);
        checkOutput("vabort_no_done", doneCount - d0, 0);
        checkOutput("vabort_count", frame_count, expCount);
        fillRandom();
        expBmp = modelBitmap();
        sendFrame(-1, -1, -1);
        expCount = expCount + 8'd1;
        checkOutput("vabort_next_bmp", bmpOutput, expBmp);
        checkOutput("vabort_next_count", frame_count, expCount);

        // Short line in row 3, then a good frame
        keepBmp = bmpOutput;
        e0 = errCount;
        fillRandom();
        sendFrame(-1, 3, -1);
        repeat (3) @(posedge dclk);
        checkOutput("short_err", errCount - e0, 1);
        checkOutput("short_bmp_kept", bmpOutput, keepBmp);
        checkOutput("short_count", frame_count, expCount);
        fillRandom();
        expBmp = modelBitmap();
        sendFrame(-1, -1, -1);
        expCount = expCount + 8'd1;
        checkOutput("short_next_bmp", bmpOutput, expBmp);
        checkOutput("short_next_count", frame_count, expCount);

        // One-cycle clr pulse mid-ACTIVE while the stream continues
        d0 = doneCount;
        fillRandom();
        sendFrame(-1, -1, 4);
        expCount = 8'd0;
        checkOutput("midrst_bmp", bmpOutput, '0);
        checkOutput("midrst_count", frame_count, expCount);
        checkOutput("midrst_no_done", doneCount - d0, 0);
        fillRandom();
        expBmp = modelBitmap();
        sendFrame(-1, -1, -1);
        expCount = expCount + 8'd1;
        checkOutput("midrst_next_bmp", bmpOutput, expBmp);
        checkOutput("midrst_next_count", frame_count, expCount);

        // 256 good frames from reset: counter wraps back to 0
        clrNext = 1'b0;
        repeat (2) junk(1'b1, 1'b1);
        clrNext = 1'b1;
        junk(1'b1, 1'b1);
        expCount = 8'd0;
        d0 = doneCount;
        for (int f = 0; f < 256; f++) begin
            fillRandom();
            expBmp = modelBitmap();
            sendFrame(-1, -1, -1);
            expCount = expCount + 8'd1;
            if (f == 0) checkOutput("wrap_first_count", frame_count, expCount);
        end
        checkOutput("wrap_count", frame_count, expCount);
        checkOutput("wrap_done_pulses", doneCount - d0, 256);
        checkOutput("wrap_last_bmp", bmpOutput, expBmp);

        // Whole-run properties
        checkOutput("total_err_pulses", errCount, 2);
        checkOutput("bmp_stable", glitchCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
